tone_monitor: RTL

//  Synthesizable per-channel audio tone checker: moving-average smoothing, hysteretic
//  neg->pos zero-crossing detection, period (in samples) and peak-amplitude measurement,

---
 rtl/tone_monitor.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tone_monitor.sv
// tone_monitor: per-channel audio tone checker on the codec output sample path.
// Each channel smooths its samples with a moving average. It detects neg->pos
// crossings of the smoothed signal with hysteresis. It measures the period (in
// samples) and the peak between consecutive rising crossings. It checks both
// against limits and counts violations in saturating error counters.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   smpl_vld       one-cycle strobe: smpl_in carries a new sample for every channel
//   smpl_in        signed samples, channel c at [c*DW +: DW]
//   min_per/max_per    legal period range in samples, inclusive
//   min_ampl/max_ampl  legal signed peak range, inclusive
//   clr_err        synchronous clear of all error counters
//   avg_out        smoothed sample per channel (one cycle after smpl_vld)
//   meas_vld       per-channel pulse: new per_out/peak_out (two cycles after smpl_vld)
//   per_out        last measured period per channel
//   peak_out       last measured peak per channel
//   freq_err       period-violation count per channel
//   ampl_err       peak-violation count per channel
module tone_monitor #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned DW       = 16,
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned PER_W    = 12,
    parameter int unsigned HYST     = 64,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 smpl_vld,
    input  logic [NCH*DW-1:0]    smpl_in,
    input  logic [PER_W-1:0]     min_per,
    input  logic [PER_W-1:0]     max_per,
    input  logic [DW-1:0]        min_ampl,
    input  logic [DW-1:0]        max_ampl,
    input  logic                 clr_err,
    output logic [NCH*DW-1:0]    avg_out,
    output logic [NCH-1:0]       meas_vld,
    output logic [NCH*PER_W-1:0] per_out,
    output logic [NCH*DW-1:0]    peak_out,
    output logic [NCH*ERR_W-1:0] freq_err,
    output logic [NCH*ERR_W-1:0] ampl_err
);

    typedef enum logic [1:0] {UNARMED, NEG, POS} state_t;

    localparam int unsigned WIN = 2**AVG_LOG2;
    localparam int unsigned SW  = DW + AVG_LOG2;

    localparam logic signed [DW-1:0] HYST_P  = DW'(HYST);
    localparam logic signed [DW-1:0] HYST_N  = -HYST_P;
    localparam logic [PER_W-1:0]     CNT_MAX = '1;
    localparam logic [ERR_W-1:0]     ERR_MAX = '1;

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            logic signed [DW-1:0]  hist [WIN];
            logic [AVG_LOG2-1:0]   wptr;
            logic signed [DW-1:0]  x, oldest;
            logic signed [SW-1:0]  sum, sum_nx;
            logic signed [DW-1:0]  avg;
            logic                  avg_stb;
            state_t                state, state_nx;
            logic                  rise;
            logic                  armed;
            logic [PER_W-1:0]      cnt;
            logic signed [DW-1:0]  pk;
            logic                  meas_q;
            logic [PER_W-1:0]      per_q;
            logic signed [DW-1:0]  peak_q;
            logic [ERR_W-1:0]      ferr, aerr;
            logic                  meas_evt, f_bad, a_bad;

            assign x      = smpl_in[c*DW +: DW];
            assign oldest = hist[wptr];
            assign sum_nx = sum + $signed({{AVG_LOG2{x[DW-1]}}, x})
                                - $signed({{AVG_LOG2{oldest[DW-1]}}, oldest});

            // Smoothing: circular history plus running sum; avg_stb marks the
            // cycle in which avg holds a freshly computed value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < WIN; i++) hist[i] <= '0;
                    wptr    <= '0;
                    sum     <= '0;
                    avg     <= '0;
                    avg_stb <= 1'b0;
                end else begin
                    avg_stb <= smpl_vld;
                    if (smpl_vld) begin
                        hist[wptr] <= x;
                        wptr       <= wptr + AVG_LOG2'(1);
                        sum        <= sum_nx;
                        avg        <= sum_nx[SW-1:AVG_LOG2];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) state <= UNARMED;
                else        state <= state_nx;
            end

            always_comb begin
                state_nx = state;
                rise     = 1'b0;
                if (avg_stb) begin
                    case (state)
                        UNARMED: if (avg < HYST_N) state_nx = NEG;
                        NEG: if (avg >= HYST_P) begin
                            state_nx = POS;
                            rise     = 1'b1;
                        end
                        POS:     if (avg <= HYST_N) state_nx = NEG;
                        default: state_nx = UNARMED;
                    endcase
                end
            end

            // A measurement closes on every rising event except the one that arms.
            assign meas_evt = avg_stb && rise && armed;
            assign f_bad    = meas_evt && ((cnt < min_per) || (cnt > max_per) || (cnt == CNT_MAX));
            assign a_bad    = meas_evt && ((pk < $signed(min_ampl)) || (pk > $signed(max_ampl)));

            // The crossing sample opens the new period, so it seeds cnt=1 and pk
            // rather than contributing to the period being closed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    armed  <= 1'b0;
                    cnt    <= '0;
                    pk     <= '0;
                    meas_q <= 1'b0;
                    per_q  <= '0;
                    peak_q <= '0;
                end else begin
                    meas_q <= 1'b0;
                    if (avg_stb) begin
                        if (rise) begin
                            if (armed) begin
                                meas_q <= 1'b1;
                                per_q  <= cnt;
                                peak_q <= pk;
                            end
                            armed <= 1'b1;
                            cnt   <= PER_W'(1);
                            pk    <= avg;
                        end else if (armed) begin
                            if (cnt != CNT_MAX) cnt <= cnt + PER_W'(1);
                            if (avg > pk)       pk  <= avg;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ferr <= '0;
                    aerr <= '0;
                end else if (clr_err) begin
                    ferr <= '0;
                    aerr <= '0;
                end else begin
                    if (f_bad && (ferr != ERR_MAX)) ferr <= ferr + ERR_W'(1);
                    if (a_bad && (aerr != ERR_MAX)) aerr <= aerr + ERR_W'(1);
                end
            end

            assign avg_out[c*DW +: DW]       = avg;
            assign meas_vld[c]               = meas_q;
            assign per_out[c*PER_W +: PER_W] = per_q;
            assign peak_out[c*DW +: DW]      = peak_q;
            assign freq_err[c*ERR_W +: ERR_W] = ferr;
            assign ampl_err[c*ERR_W +: ERR_W] = aerr;
        end
    endgenerate

endmodule
